fclk_en_gen: RTL and testbench

FCLK_EN_GEN -- requirements
Module: fclk_en_gen

---
 rtl/fclk_en_gen.sv | 184 ++++++++++++++++++
 tb/tb_fclk_en_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fclk_en_gen.sv
// Purpose: per-channel clock-enable pulse generator gated by a qualified PLL lock indication.
// Latency: locked_o rises LOCK_CYCLES+3 edges after pll_locked rises; first pulse in the D-th RUN cycle.
// Backpressure: none; strobes are taken every cycle, divisor writes to counting channels wait for a wrap.
module fclk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              div_load,
  input  logic [3:0]        div_ch,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_en,
  output logic              locked_o,
  output logic [7:0]        lost_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int            QW   = $clog2(LOCK_CYCLES);
  localparam logic [QW-1:0] QMAX = QW'(LOCK_CYCLES - 1);

  logic          lk_m;
  logic          lk_s;
  state_t        state_q;
  state_t        state_d;
  logic [QW-1:0] qcnt_q;
  logic [QW-1:0] qcnt_d;
  logic          lost_inc;

  logic [DIV_W-1:0] div_q  [NUM_CH];
  logic [DIV_W-1:0] div_d  [NUM_CH];
  logic [DIV_W-1:0] cnt_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_d  [NUM_CH];
  logic [DIV_W-1:0] pend_q [NUM_CH];
  logic [DIV_W-1:0] pend_d [NUM_CH];
  logic [NUM_CH-1:0] pv_q;
  logic [NUM_CH-1:0] pv_d;
  logic [NUM_CH-1:0] act_q;
  logic [NUM_CH-1:0] act_d;
  logic [NUM_CH-1:0] clk_en_q;
  logic [NUM_CH-1:0] clk_en_d;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] wrap;
  logic              run_now;
  logic              run_nxt;
  logic              restart;
  logic [DIV_W-1:0]  ld_val;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
    end
  end

  // Lock FSM state, qualification counter and saturating loss counter.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      qcnt_q   <= '0;
      lost_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      if (lost_inc && (lost_cnt != 8'hFF)) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

  // Lock qualification: lk_s must stay high for LOCK_CYCLES STABLE cycles before RUN.
  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    lost_inc = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = STABLE;
          qcnt_d  = '0;
        end
      end
      STABLE: begin
        qcnt_d = qcnt_q + QW'(1);
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (qcnt_q == QMAX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          lost_inc = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
  end

  // Per-channel divisor, shadow and phase next-state; clk_en is precomputed so the port comes straight from a flop.
  always_comb begin
    div_d    = div_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    pv_d     = pv_q;
    act_d    = '0;
    clk_en_d = '0;
    hit      = '0;
    wrap     = '0;
    run_now  = (state_q == RUN);
    run_nxt  = (state_d == RUN);
    restart  = sync_restart && run_now;
    ld_val   = (div_val == '0) ? DIV_W'(1) : div_val;
    for (int i = 0; i < NUM_CH; i++) begin
      // Indices at or above NUM_CH never match a channel, so such writes drop out here.
      hit[i]  = div_load && (div_ch == 4'(i));
      wrap[i] = act_q[i] && (cnt_q[i] == (div_q[i] - DIV_W'(1)));
      act_d[i] = run_nxt && ch_enable[i];

      // A running period is never cut short: writes wait in the shadow until the wrap or a restart.
      if (hit[i]) begin
        if (!act_q[i] || wrap[i] || restart) begin
          div_d[i] = ld_val;
          pv_d[i]  = 1'b0;
        end else begin
          pend_d[i] = ld_val;
          pv_d[i]   = 1'b1;
        end
      end else if (pv_q[i] && (wrap[i] || restart)) begin
        div_d[i] = pend_q[i];
        pv_d[i]  = 1'b0;
      end

      if (!act_d[i] || restart || !act_q[i] || wrap[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end

      clk_en_d[i] = act_d[i] && !restart && (cnt_d[i] == (div_d[i] - DIV_W'(1)));
    end
  end

  // Channel state registers; divisors come out of reset as 1.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= DIV_W'(1);
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      pv_q     <= '0;
      act_q    <= '0;
      clk_en_q <= '0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pv_q     <= pv_d;
      act_q    <= act_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk_en   = clk_en_q;
  assign locked_o = (state_q == RUN);

endmodule

// File: tb/tb_fclk_en_gen.sv
// Purpose: self-checking bench for fclk_en_gen against a cycle-level behavioural model.
// Latency: outputs compared 1 time unit after every rising refclk edge.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_fclk_en_gen;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int LC  = 16;

  logic           refclk = 1'b0;
  logic           rst;
  logic           pll_locked;
  logic [NCH-1:0] ch_enable;
  logic           div_load;
  logic [3:0]     div_ch;
  logic [DW-1:0]  div_val;
  logic           sync_restart;
  logic [NCH-1:0] clk_en;
  logic           locked_o;
  logic [7:0]     lost_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: lock is a streak of raw samples seen two edges late; channels count down to their pulse.
  logic           pll_hist[$];
  int             streak;
  bit             m_run;
  int             m_lost;
  bit             m_act [NCH];
  int             m_rem [NCH];
  int             m_d   [NCH];
  int             m_p   [NCH];
  bit             m_pv  [NCH];
  logic [NCH-1:0] m_pulse;
  logic [3:0]     exp_pat [6];

  fclk_en_gen #(
    .NUM_CH(NCH),
    .DIV_W(DW),
    .LOCK_CYCLES(LC)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .ch_enable(ch_enable),
    .div_load(div_load),
    .div_ch(div_ch),
    .div_val(div_val),
    .sync_restart(sync_restart),
    .clk_en(clk_en),
    .locked_o(locked_o),
    .lost_cnt(lost_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit seen;
    bit run_next;
    bit restart;
    bit act_next;
    bit wrapping;
    bit hit;
    int val;
    if (rst) begin
      pll_hist.delete();
      pll_hist.push_back(1'b0);
      pll_hist.push_back(1'b0);
      streak  = 0;
      m_run   = 1'b0;
      m_lost  = 0;
      m_pulse = '0;
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = 1'b0;
        m_rem[i] = 0;
        m_d[i]   = 1;
        m_p[i]   = 0;
        m_pv[i]  = 1'b0;
      end
    end else begin
      seen = pll_hist.pop_front();
      pll_hist.push_back(pll_locked);
      streak   = seen ? streak + 1 : 0;
      run_next = (streak >= LC + 1);
      restart  = sync_restart && m_run;
      val      = (div_val == 0) ? 1 : int'(div_val);
      for (int i = 0; i < NCH; i++) begin
        hit      = div_load && (int'(div_ch) == i);
        wrapping = m_act[i] && (m_rem[i] == 1);
        act_next = run_next && ch_enable[i];
        if (hit) begin
          if (!m_act[i] || wrapping || restart) begin
            m_d[i]  = val;
            m_pv[i] = 1'b0;
          end else begin
            m_p[i]  = val;
            m_pv[i] = 1'b1;
          end
        end else if (m_pv[i] && (wrapping || restart)) begin
          m_d[i]  = m_p[i];
          m_pv[i] = 1'b0;
        end
        if (!act_next) begin
          m_act[i]   = 1'b0;
          m_pulse[i] = 1'b0;
        end else if (!m_act[i] || restart || wrapping) begin
          m_act[i]   = 1'b1;
          m_rem[i]   = m_d[i];
          m_pulse[i] = (m_rem[i] == 1) && !restart;
        end else begin
          m_rem[i]   = m_rem[i] - 1;
          m_pulse[i] = (m_rem[i] == 1);
        end
      end
      if (m_run && !run_next && (m_lost < 255)) m_lost++;
      m_run = run_next;
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
    chk("clk_en", 32'(clk_en), 32'(m_pulse));
    chk("locked_o", 32'(locked_o), 32'(m_run));
    chk("lost_cnt", 32'(lost_cnt), 32'(m_lost));
  endtask

  task automatic load(input int ch, input int v);
    div_load = 1'b1;
    div_ch   = 4'(ch);
    div_val  = DW'(v);
    tick();
    div_load = 1'b0;
  endtask

  // Directed scenarios followed by a randomized soak, all checked every cycle against the model.
  initial begin
    rst = 1'b1; pll_locked = 1'b1; ch_enable = '0; div_load = 1'b0;
    div_ch = '0; div_val = '0; sync_restart = 1'b0;
    exp_pat = '{4'b0001, 4'b0011, 4'b0101, 4'b0011, 4'b1001, 4'b0111};

    // Reset wins over a high lock input.
    repeat (3) tick();
    chk("rst_locked_o", 32'(locked_o), 32'd0);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_lost_cnt", 32'(lost_cnt), 32'd0);

    // Lock qualification takes LC+3 edges.
    rst = 1'b0;
    for (int e = 1; e <= LC + 3; e++) begin
      tick();
      if (e == LC + 2) chk("lock_early", 32'(locked_o), 32'd0);
    end
    chk("lock_edge", 32'(locked_o), 32'd1);

    // A one-edge glitch restarts qualification.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int e = 1; e <= LC + 13; e++) begin
      pll_locked = (e != 10);
      tick();
      if (e == LC + 3)  chk("glitch_no_run", 32'(locked_o), 32'd0);
      if (e == LC + 12) chk("glitch_not_yet", 32'(locked_o), 32'd0);
    end
    chk("glitch_relock", 32'(locked_o), 32'd1);

    // Divisors 1,2,3,5 aligned to RUN entry.
    rst = 1'b1; pll_locked = 1'b0; tick(); rst = 1'b0;
    load(0, 1); load(1, 2); load(2, 3); load(3, 5);
    ch_enable = '1; pll_locked = 1'b1;
    for (int e = 1; e <= LC + 3; e++) tick();
    for (int k = 0; k < 6; k++) begin
      chk("align", 32'(clk_en), 32'(exp_pat[k]));
      tick();
    end
    repeat (20) tick();

    // Channel 1 at D=4, rewritten to 2 at phase 1: old period completes first.
    ch_enable[1] = 1'b0; tick();
    load(1, 4);
    ch_enable[1] = 1'b1; tick(); tick();
    div_load = 1'b1; div_ch = 4'd1; div_val = 8'd2; tick(); div_load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("reload_ch1", 32'(clk_en[1]), 32'(k % 2));
      tick();
    end

    // Last write wins while a write is pending.
    div_load = 1'b1; div_ch = 4'd2; div_val = 8'd6; tick();
    div_val = 8'd4; tick(); div_load = 1'b0;
    repeat (16) tick();

    // Restart mid-period with D=3 and D=4.
    ch_enable = '0; tick();
    load(0, 3); load(1, 4);
    ch_enable = 4'b0011;
    repeat (5) tick();
    sync_restart = 1'b1; tick(); sync_restart = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("restart", 32'(clk_en[1:0]), (k == 2) ? 32'd1 : ((k == 3) ? 32'd2 : 32'd0));
      tick();
    end

    // Divisor 0 behaves as 1; out-of-range channel index is ignored.
    ch_enable = '0; tick();
    load(0, 0);
    ch_enable = 4'b0001; tick();
    for (int k = 0; k < 3; k++) begin
      chk("div_zero", 32'(clk_en[0]), 32'd1);
      tick();
    end
    div_load = 1'b1; div_ch = 4'd9; div_val = 8'd7; tick(); div_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bad_ch", 32'(clk_en[0]), 32'd1);
      tick();
    end

    // Repeated lock loss with full requalification; loss count saturates.
    ch_enable = '1;
    for (int it = 0; it < 300; it++) begin
      for (int e = 0; e < 25; e++) begin
        pll_locked = (e >= 5);
        tick();
        if (it == 0 && e == 1) chk("loss_still_run", 32'(locked_o), 32'd1);
        if (it == 0 && e == 2) begin
          chk("loss_locked_o", 32'(locked_o), 32'd0);
          chk("loss_clk_en", 32'(clk_en), 32'd0);
          chk("loss_count", 32'(lost_cnt), 32'd1);
        end
        if (it == 0 && e == 22) chk("relock_early", 32'(locked_o), 32'd0);
        if (it == 0 && e == 23) chk("relock", 32'(locked_o), 32'd1);
      end
    end
    chk("lost_sat", 32'(lost_cnt), 32'd255);

    // Randomized soak.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (pll_locked) begin
        if ($urandom_range(0, 149) == 0) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 5) == 0) pll_locked = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) ch_enable = NCH'($urandom);
      div_load = ($urandom_range(0, 4) == 0);
      div_ch   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      div_val  = DW'($urandom_range(0, 6));
      sync_restart = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 1'b0; div_load = 1'b0; sync_restart = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
